// File: rtl/alu_sequencer.sv
// Sequences one ALU instruction through IDLE/READ/EXEC/WB against a 4x16 register file and carry flag.
// Optional ALU_SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction counter port (retire_cnt).
module alu_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [15:0]   instr_data,
    output logic          instr_ready,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [DW-1:0] wr_data,
    output logic [15:0]   alu_instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_cout,
    output logic          done,
    output logic          illegal,
    output logic          carry_flag,
`ifdef ALU_SEQ_RETIRE_CNT_EN
    output logic [15:0]   retire_cnt,
`endif
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t        state_q, state_d;
    logic [15:0]   instr_q, instr_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          alu_cin_q, alu_cin_d;
    logic [DW-1:0] result_q, result_d;
    logic          cout_q, cout_d;
    logic          done_q, done_d;
    logic          illegal_q, illegal_d;
    logic          carry_q, carry_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          op_legal;

    // Legal opcodes are exactly F8..FB.
    assign op_legal = (instr_q[15:10] == 6'b111110);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        result_d  = result_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        regs_d    = regs_q;
        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    regs_d[wr_sel] = wr_data;
                end else if (instr_valid) begin
                    // Regfile cannot change between accept and READ, so operands are captured
                    // here and presented as stable registered outputs for READ and EXEC.
                    instr_d   = instr_data;
                    alu_a_d   = regs_q[instr_data[5:4]];
                    alu_b_d   = regs_q[instr_data[3:2]];
                    alu_cin_d = instr_data[0] & carry_q;
                    state_d   = S_READ;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                result_d  = alu_result;
                cout_d    = alu_cout;
                done_d    = op_legal;
                illegal_d = ~op_legal;
                state_d   = S_WB;
            end
            S_WB: begin
                if (op_legal) begin
                    regs_d[instr_q[7:6]] = result_q;
                    if (instr_q[1]) carry_d = cout_q;
                    cnt_d = cnt_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Host writes take priority over instruction accept in IDLE.
    assign instr_ready = (state_q == S_IDLE) & ~wr_en;
    assign alu_instr   = instr_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cin     = alu_cin_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign carry_flag  = carry_q;
    assign dbg_data    = regs_q[dbg_sel];

`ifdef ALU_SEQ_RETIRE_CNT_EN
    assign retire_cnt = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions, behavioural ALU, pulse/latency monitor.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = '0;
    logic        instr_ready;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sel = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] alu_instr, alu_a, alu_b;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        done, illegal, carry_flag;
    logic [1:0]  dbg_sel = '0;
    logic [15:0] dbg_data;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .done(done), .illegal(illegal), .carry_flag(carry_flag),
`ifdef ALU_SEQ_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU attached to the sequencer's outputs.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (alu_instr[15:8])
            8'hF8:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            8'hF9:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
            8'hFA:   alu_sum = {1'b0, alu_a} + 17'd1;
            8'hFB:   alu_sum = {1'b0, alu_a} + 17'h0FFFF;
            default: alu_sum = '0;
        endcase
    end
    assign alu_result = alu_sum[15:0];
    assign alu_cout   = alu_sum[16];

    typedef struct {
        logic ill;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every retire/discard pulse must match the oldest outstanding instruction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && illegal) chk("done_and_illegal", 1, 0);
            if (done || illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {done, illegal}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind_illegal", illegal, e.ill);
                    chk("pulse_cycle", cyc, e.cyc + 3);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] d, input logic ill, output int hs);
        exp_t e;
        instr_data  = d;
        instr_valid = 1'b1;
        hs = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        e.ill = ill;
        e.cyc = hs;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("retire_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic hwrite(input logic [1:0] sel, input logic [15:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] sel, input logic [15:0] exp);
        dbg_sel = sel;
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        wr_en = 1'b0;
        sb.delete();
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    int hs0, hs1, hs2, hw;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_alu_instr", alu_instr, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_carry", carry_flag, 0);
        chk_reg("rst_r1", 2'd1, 16'h0000);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("rst_retire_cnt", retire_cnt, 0);
`endif
        @(posedge clk); #1;

        // 1: 5 + 3 -> R0
        hwrite(2'd1, 16'h0005);
        hwrite(2'd2, 16'h0003);
        issue(16'hF818, 1'b0, hs0);
        instr_valid = 1'b0;
        wait_idle();
        chk_reg("t1_r0", 2'd0, 16'h0008);
        chk("t1_carry", carry_flag, 0);

        // 2: FFFF + 1 with carry enable, then 1 + 1 + carry
        hwrite(2'd1, 16'hFFFF);
        hwrite(2'd2, 16'h0001);
        issue(16'hF81A, 1'b0, hs0);
        instr_valid = 1'b0;
        wait_idle();
        chk_reg("t2_r0", 2'd0, 16'h0000);
        chk("t2_carry", carry_flag, 1);
        issue(16'hF8E9, 1'b0, hs0);
        instr_valid = 1'b0;
        wait_idle();
        chk_reg("t2_r3", 2'd3, 16'h0003);
        chk("t2_carry_kept", carry_flag, 1);

        // 3: illegal opcode
        issue(16'h1218, 1'b1, hs0);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_ready_t3", instr_ready, 0);
        @(negedge clk);
        chk("t3_ready_t4", instr_ready, 1);
        @(posedge clk); #1;
        chk_reg("t3_r0", 2'd0, 16'h0000);
        chk_reg("t3_r3", 2'd3, 16'h0003);
        chk("t3_carry", carry_flag, 1);

        // 4: three back-to-back increments of R1 from a fresh reset
        do_reset();
        issue(16'hFA50, 1'b0, hs0);
        issue(16'hFA50, 1'b0, hs1);
        issue(16'hFA50, 1'b0, hs2);
        instr_valid = 1'b0;
        chk("t4_hs1", hs1, hs0 + 4);
        chk("t4_hs2", hs2, hs0 + 8);
        wait_idle();
        chk_reg("t4_r1", 2'd1, 16'h0003);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("t4_retire_cnt", retire_cnt, 3);
`endif

        // 5: host write beats a pending instruction; write during EXEC ignored
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 16'h00AA;
        instr_valid = 1'b1; instr_data = 16'hFA50;
        @(negedge clk);
        chk("t5_ready_during_write", instr_ready, 0);
        hw = cyc;
        @(posedge clk); #1;
        wr_en = 1'b0;
        issue(16'hFA50, 1'b0, hs0);
        instr_valid = 1'b0;
        chk("t5_accept_after_write", hs0, hw + 1);
        wait_idle();
        chk_reg("t5_r1", 2'd1, 16'h00AB);
        issue(16'hFB50, 1'b0, hs0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = 2'd2; wr_data = 16'h1234;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_idle();
        chk_reg("t5_r2_ignored", 2'd2, 16'h0000);
        chk_reg("t5_r1_dec", 2'd1, 16'h00AA);

        // 6: reset during EXEC aborts the instruction
        hwrite(2'd2, 16'hFF80);
        issue(16'hF81A, 1'b0, hs0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #4;
        chk("t6_done_in_reset", done, 0);
        #3 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_ready", instr_ready, 1);
        chk("t6_carry", carry_flag, 0);
        chk_reg("t6_r0", 2'd0, 16'h0000);
        chk_reg("t6_r1", 2'd1, 16'h0000);
        chk_reg("t6_r2", 2'd2, 16'h0000);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("t6_retire_cnt", retire_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
